// File: rtl/rob_multi_commit.sv
// +----------------------------------------------------------------------------+
// | Module      : rob_multi_commit                                             |
// | Description : Reorder buffer with NUM_WB writeback ports, up to two        |
// |               in-order retirements per cycle and registered mispredict     |
// |               flush.                                                       |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module rob_multi_commit #(
    parameter int ROB_WIDTH_BIT = 4,
    parameter int NUM_WB        = 2,
    parameter int DUAL_COMMIT   = 1
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic                            rdy_in,
    input  logic                            alloc_valid,
    input  logic                            alloc_done,
    input  logic [31:0]                     alloc_value,
    input  logic [4:0]                      alloc_rd,
    input  logic [1:0]                      alloc_type,
    input  logic [31:0]                     alloc_pc,
    input  logic [31:0]                     alloc_pred,
    output logic [ROB_WIDTH_BIT-1:0]        alloc_id,
    output logic                            rob_full,
    output logic [ROB_WIDTH_BIT:0]          rob_count,
    input  logic [NUM_WB-1:0]               wb_valid,
    input  logic [NUM_WB*ROB_WIDTH_BIT-1:0] wb_id,
    input  logic [NUM_WB*32-1:0]            wb_val,
    output logic                            cm0_valid,
    output logic                            cm1_valid,
    output logic                            cm0_wr,
    output logic                            cm1_wr,
    output logic [4:0]                      cm0_rd,
    output logic [4:0]                      cm1_rd,
    output logic [31:0]                     cm0_val,
    output logic [31:0]                     cm1_val,
    output logic [ROB_WIDTH_BIT-1:0]        cm0_id,
    output logic [ROB_WIDTH_BIT-1:0]        cm1_id,
    output logic                            head_is_mem,
    output logic [ROB_WIDTH_BIT-1:0]        head_id,
    input  logic [2*ROB_WIDTH_BIT-1:0]      q_id,
    output logic [1:0]                      q_ready,
    output logic [63:0]                     q_val,
    output logic                            flush,
    output logic [31:0]                     flush_pc
);

    localparam int         C_DEPTH       = 1 << ROB_WIDTH_BIT;
    localparam logic [1:0] C_TYPE_REG    = 2'd0;
    localparam logic [1:0] C_TYPE_STORE  = 2'd1;
    localparam logic [1:0] C_TYPE_BRANCH = 2'd2;
    localparam logic [1:0] C_TYPE_LOAD   = 2'd3;

    logic [ROB_WIDTH_BIT-1:0]      head_q, head_d, tail_q, tail_d;
    logic [ROB_WIDTH_BIT:0]        count_q, count_d;
    logic [C_DEPTH-1:0]            busy_q, busy_d, done_q, done_d;
    logic [C_DEPTH-1:0][31:0]      value_q, value_d, pred_q, pred_d;
    logic [C_DEPTH-1:0][4:0]       rd_q, rd_d;
    logic [C_DEPTH-1:0][1:0]       type_q, type_d;
    logic                          flush_q, flush_d;
    logic [31:0]                   flush_pc_q, flush_pc_d;

    logic [ROB_WIDTH_BIT-1:0]      w_head_p1;
    logic                          w_head_mem, w_next_mem;
    logic                          w_alloc_accept;
    logic                          w_mispredict;
    logic [1:0]                    w_n_commit;
    logic                          w_unused_pc;

    // Instruction address is carried for the Decoder's benefit only.
    assign w_unused_pc = ^alloc_pc;

    assign w_head_p1  = head_q + ROB_WIDTH_BIT'(1);
    assign w_head_mem = (type_q[head_q] == C_TYPE_STORE) || (type_q[head_q] == C_TYPE_LOAD);
    assign w_next_mem = (type_q[w_head_p1] == C_TYPE_STORE) || (type_q[w_head_p1] == C_TYPE_LOAD);

    assign rob_full  = (count_q == (ROB_WIDTH_BIT+1)'(C_DEPTH));
    assign rob_count = count_q;
    assign alloc_id  = tail_q;
    assign head_id   = head_q;
    assign head_is_mem = busy_q[head_q] && w_head_mem;
    assign flush     = flush_q;
    assign flush_pc  = flush_pc_q;

    assign cm0_valid = rdy_in && !flush_q && busy_q[head_q] && done_q[head_q];
    assign cm1_valid = (DUAL_COMMIT != 0) && cm0_valid
                       && (type_q[head_q] != C_TYPE_BRANCH)
                       && !w_head_mem && !w_next_mem
                       && busy_q[w_head_p1] && done_q[w_head_p1];

    assign cm0_wr  = cm0_valid && ((type_q[head_q] == C_TYPE_REG) || (type_q[head_q] == C_TYPE_LOAD))
                     && (rd_q[head_q] != 5'd0);
    assign cm1_wr  = cm1_valid && ((type_q[w_head_p1] == C_TYPE_REG) || (type_q[w_head_p1] == C_TYPE_LOAD))
                     && (rd_q[w_head_p1] != 5'd0);
    assign cm0_rd  = rd_q[head_q];
    assign cm1_rd  = rd_q[w_head_p1];
    assign cm0_val = value_q[head_q];
    assign cm1_val = value_q[w_head_p1];
    assign cm0_id  = head_q;
    assign cm1_id  = w_head_p1;

    assign w_alloc_accept = rdy_in && !flush_q && alloc_valid && !rob_full;
    assign w_mispredict   = cm0_valid && (type_q[head_q] == C_TYPE_BRANCH)
                            && (value_q[head_q] != pred_q[head_q]);
    assign w_n_commit     = {1'b0, cm0_valid} + {1'b0, cm1_valid};

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        busy_d     = busy_q;
        done_d     = done_q;
        value_d    = value_q;
        pred_d     = pred_q;
        rd_d       = rd_q;
        type_d     = type_q;
        flush_d    = flush_q;
        flush_pc_d = flush_pc_q;
        if (rdy_in) begin
            if (flush_q) begin
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
                busy_d  = '0;
                done_d  = '0;
                flush_d = 1'b0;
            end else begin
                // Ascending port order lets the highest port win on a shared id.
                for (int k = 0; k < NUM_WB; k++) begin
                    if (wb_valid[k] && busy_q[wb_id[k*ROB_WIDTH_BIT +: ROB_WIDTH_BIT]]) begin
                        done_d[wb_id[k*ROB_WIDTH_BIT +: ROB_WIDTH_BIT]]  = 1'b1;
                        value_d[wb_id[k*ROB_WIDTH_BIT +: ROB_WIDTH_BIT]] = wb_val[k*32 +: 32];
                    end
                end
                if (cm0_valid) begin
                    busy_d[head_q] = 1'b0;
                    done_d[head_q] = 1'b0;
                end
                if (cm1_valid) begin
                    busy_d[w_head_p1] = 1'b0;
                    done_d[w_head_p1] = 1'b0;
                end
                if (w_alloc_accept) begin
                    busy_d[tail_q]  = 1'b1;
                    done_d[tail_q]  = alloc_done;
                    value_d[tail_q] = alloc_value;
                    pred_d[tail_q]  = alloc_pred;
                    rd_d[tail_q]    = alloc_rd;
                    type_d[tail_q]  = alloc_type;
                end
                head_d  = head_q + ROB_WIDTH_BIT'(w_n_commit);
                tail_d  = tail_q + ROB_WIDTH_BIT'(w_alloc_accept);
                count_d = count_q + (ROB_WIDTH_BIT+1)'(w_alloc_accept)
                                  - (ROB_WIDTH_BIT+1)'(w_n_commit);
                if (w_mispredict) begin
                    flush_d    = 1'b1;
                    flush_pc_d = value_q[head_q];
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            busy_q     <= '0;
            done_q     <= '0;
            flush_q    <= 1'b0;
            flush_pc_q <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            flush_q    <= flush_d;
            flush_pc_q <= flush_pc_d;
        end
    end

    always_ff @(posedge clk_in) begin
        value_q <= value_d;
        pred_q  <= pred_d;
        rd_q    <= rd_d;
        type_q  <= type_d;
    end

    for (genvar j = 0; j < 2; j++) begin : g_query
        logic [ROB_WIDTH_BIT-1:0] w_id;
        logic                     w_rdy;
        logic [31:0]              w_val;

        assign w_id = q_id[j*ROB_WIDTH_BIT +: ROB_WIDTH_BIT];

        always_comb begin
            w_rdy = 1'b0;
            w_val = 32'd0;
            if (done_q[w_id]) begin
                w_rdy = 1'b1;
                w_val = value_q[w_id];
            end else begin
                for (int k = 0; k < NUM_WB; k++) begin
                    if (wb_valid[k] && (wb_id[k*ROB_WIDTH_BIT +: ROB_WIDTH_BIT] == w_id)) begin
                        w_rdy = 1'b1;
                        w_val = wb_val[k*32 +: 32];
                    end
                end
                if (!w_rdy && alloc_valid && alloc_done && (w_id == tail_q)) begin
                    w_rdy = 1'b1;
                    w_val = alloc_value;
                end
            end
        end

        assign q_ready[j]        = w_rdy;
        assign q_val[j*32 +: 32] = w_val;
    end

endmodule

`default_nettype wire

// File: tb/tb_rob_multi_commit.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_rob_multi_commit                                          |
// | Description : Scoreboard bench for rob_multi_commit against a queue model. |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_rob_multi_commit;

    localparam int W     = 4;
    localparam int DEPTH = 16;
    localparam int NWB   = 2;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in;
    logic        alloc_valid, alloc_done;
    logic [31:0] alloc_value, alloc_pc, alloc_pred;
    logic [4:0]  alloc_rd;
    logic [1:0]  alloc_type;
    logic [W-1:0] alloc_id;
    logic        rob_full;
    logic [W:0]  rob_count;
    logic [NWB-1:0]   wb_valid;
    logic [NWB*W-1:0] wb_id;
    logic [NWB*32-1:0] wb_val;
    logic        cm0_valid, cm1_valid, cm0_wr, cm1_wr;
    logic [4:0]  cm0_rd, cm1_rd;
    logic [31:0] cm0_val, cm1_val;
    logic [W-1:0] cm0_id, cm1_id;
    logic        head_is_mem;
    logic [W-1:0] head_id;
    logic [2*W-1:0] q_id;
    logic [1:0]  q_ready;
    logic [63:0] q_val;
    logic        flush;
    logic [31:0] flush_pc;

    always #5 clk_in = ~clk_in;

    rob_multi_commit #(.ROB_WIDTH_BIT(W), .NUM_WB(NWB), .DUAL_COMMIT(1)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .alloc_valid(alloc_valid), .alloc_done(alloc_done), .alloc_value(alloc_value),
        .alloc_rd(alloc_rd), .alloc_type(alloc_type), .alloc_pc(alloc_pc),
        .alloc_pred(alloc_pred), .alloc_id(alloc_id), .rob_full(rob_full),
        .rob_count(rob_count), .wb_valid(wb_valid), .wb_id(wb_id), .wb_val(wb_val),
        .cm0_valid(cm0_valid), .cm1_valid(cm1_valid), .cm0_wr(cm0_wr), .cm1_wr(cm1_wr),
        .cm0_rd(cm0_rd), .cm1_rd(cm1_rd), .cm0_val(cm0_val), .cm1_val(cm1_val),
        .cm0_id(cm0_id), .cm1_id(cm1_id), .head_is_mem(head_is_mem), .head_id(head_id),
        .q_id(q_id), .q_ready(q_ready), .q_val(q_val), .flush(flush), .flush_pc(flush_pc)
    );

    typedef struct {
        logic [W-1:0] id;
        logic [4:0]   rd;
        logic [31:0]  val;
        logic         wr;
        int           slot;
    } exp_t;

    typedef struct {
        logic [W-1:0] id;
        logic         done;
        logic [31:0]  value;
        logic [4:0]   rd;
        logic [1:0]   typ;
        logic [31:0]  pred;
    } ent_t;

    exp_t  exp_q[$];
    ent_t  mq[$];
    int    mh;
    logic  mflush;
    logic [31:0] mflush_pc;
    int    total = 0;
    int    bad   = 0;
    bit    mon_en = 1'b0;
    exp_t  mon_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic bit is_mem(input logic [1:0] t);
        return (t == 2'd1) || (t == 2'd3);
    endfunction

    // Commit monitor: pops what the model predicted for this cycle.
    always @(negedge clk_in) begin
        if (mon_en) begin
            if (cm0_valid) begin
                if (exp_q.size() == 0) check("cm0_unexpected", 1, 0);
                else begin
                    mon_e = exp_q.pop_front();
                    check("cm0_slot", 0, mon_e.slot);
                    check("cm0", {cm0_wr, cm0_rd, cm0_id, cm0_val}, {mon_e.wr, mon_e.rd, mon_e.id, mon_e.val});
                end
            end
            if (cm1_valid) begin
                if (exp_q.size() == 0) check("cm1_unexpected", 1, 0);
                else begin
                    mon_e = exp_q.pop_front();
                    check("cm1_slot", 1, mon_e.slot);
                    check("cm1", {cm1_wr, cm1_rd, cm1_id, cm1_val}, {mon_e.wr, mon_e.rd, mon_e.id, mon_e.val});
                end
            end
            check("missing_commits", exp_q.size(), 0);
            exp_q.delete();
        end
    end

    task automatic idle();
        alloc_valid = 0; alloc_done = 0; alloc_value = 0; alloc_rd = 0;
        alloc_type = 0; alloc_pc = 0; alloc_pred = 0;
        wb_valid = 0; wb_id = 0; wb_val = 0; q_id = 0;
    endtask

    task automatic alloc_set(input logic done, input logic [31:0] val, input logic [4:0] rd,
                             input logic [1:0] typ, input logic [31:0] pred);
        alloc_valid = 1; alloc_done = done; alloc_value = val; alloc_rd = rd;
        alloc_type = typ; alloc_pred = pred; alloc_pc = $urandom;
    endtask

    function automatic logic [32:0] model_query(input logic [W-1:0] id);
        int tail = (mh + mq.size()) % DEPTH;
        foreach (mq[i]) if (mq[i].id == id && mq[i].done) return {1'b1, mq[i].value};
        for (int k = NWB - 1; k >= 0; k--)
            if (wb_valid[k] && wb_id[k*W +: W] == id) return {1'b1, wb_val[k*32 +: 32]};
        if (alloc_valid && alloc_done && id == W'(tail)) return {1'b1, alloc_value};
        return 33'd0;
    endfunction

    // Called just after a rising edge with this cycle's inputs applied.
    task automatic step();
        int sz, tail, nc;
        logic newflush;
        logic [31:0] newpc;
        logic [32:0] qr;
        #1;
        sz   = mq.size();
        tail = (mh + sz) % DEPTH;
        check("count", rob_count, sz);
        check("full", rob_full, sz == DEPTH);
        check("alloc_id", alloc_id, tail);
        check("head_id", head_id, mh);
        check("head_is_mem", head_is_mem, sz > 0 && is_mem(mq[0].typ));
        check("flush", flush, mflush);
        check("flush_pc", flush_pc, mflush_pc);
        for (int j = 0; j < 2; j++) begin
            qr = model_query(q_id[j*W +: W]);
            check("q_ready", q_ready[j], qr[32]);
            check("q_val", q_val[j*32 +: 32], qr[31:0]);
        end
        if (rdy_in) begin
            if (mflush) begin
                mq.delete(); mh = 0; mflush = 0;
            end else begin
                nc = 0;
                if (sz > 0 && mq[0].done) nc = 1;
                if (nc == 1 && sz > 1 && mq[0].typ != 2'd2 && !is_mem(mq[0].typ)
                    && !is_mem(mq[1].typ) && mq[1].done) nc = 2;
                for (int i = 0; i < nc; i++) begin
                    exp_t e;
                    e.id = mq[i].id; e.rd = mq[i].rd; e.val = mq[i].value; e.slot = i;
                    e.wr = (mq[i].typ == 2'd0 || mq[i].typ == 2'd3) && mq[i].rd != 0;
                    exp_q.push_back(e);
                end
                newflush = nc > 0 && mq[0].typ == 2'd2 && mq[0].value != mq[0].pred;
                newpc    = (sz > 0) ? mq[0].value : 32'd0;
                for (int k = 0; k < NWB; k++)
                    if (wb_valid[k])
                        for (int i = 0; i < sz; i++)
                            if (mq[i].id == wb_id[k*W +: W]) begin
                                mq[i].done = 1; mq[i].value = wb_val[k*32 +: 32];
                            end
                for (int i = 0; i < nc; i++) void'(mq.pop_front());
                mh = (mh + nc) % DEPTH;
                if (alloc_valid && sz < DEPTH) begin
                    ent_t n;
                    n.id = W'(tail); n.done = alloc_done; n.value = alloc_value;
                    n.rd = alloc_rd; n.typ = alloc_type; n.pred = alloc_pred;
                    mq.push_back(n);
                end
                if (newflush) begin mflush = 1; mflush_pc = newpc; end
            end
        end
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        mon_en = 0;
        idle();
        rst_in = 1; rdy_in = 1;
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 0;
        exp_q.delete(); mq.delete();
        mh = 0; mflush = 0; mflush_pc = 0;
        mon_en = 1;
    endtask

    initial begin
        int cnt_before, done_allocs, c, idx;
        do_reset();
        check("rst_count", rob_count, 0);
        check("rst_flush", {flush, flush_pc}, 0);
        check("rst_cm", {cm0_valid, cm1_valid, cm0_wr, cm1_wr}, 0);
        check("rst_ptrs", {alloc_id, head_id}, 0);

        // Fill to capacity, then one ignored allocation.
        for (int i = 0; i < DEPTH; i++) begin
            idle(); alloc_set(0, 0, 5'(i + 1), 2'd0, 0); step();
        end
        idle(); #1;
        check("full16", rob_full, 1);
        check("count16", rob_count, 16);
        alloc_set(0, 32'h77, 5'd9, 2'd0, 0); step();
        idle(); #1;
        check("tail_after17", alloc_id, 0);
        check("count_after17", rob_count, 16);
        step();

        // Dual commit from two same-cycle writebacks.
        do_reset();
        alloc_set(0, 0, 5'd3, 2'd0, 0); step();
        idle(); alloc_set(0, 0, 5'd4, 2'd0, 0); step();
        idle(); wb_valid = 2'b11; wb_id = {4'd0, 4'd1}; wb_val = {32'h11, 32'h22}; step();
        idle(); #1;
        check("dual_valid", {cm0_valid, cm1_valid}, 2'b11);
        check("dual_vals", {cm0_val, cm1_val}, {32'h11, 32'h22});
        check("dual_ids", {cm0_id, cm1_id}, {4'd0, 4'd1});
        step();
        check("dual_head", head_id, 2);
        step();

        // STORE at head blocks the second slot.
        do_reset();
        alloc_set(0, 0, 5'd0, 2'd1, 0); step();
        idle(); alloc_set(1, 32'h33, 5'd5, 2'd0, 0); step();
        idle(); wb_valid = 2'b01; wb_id = {4'd0, 4'd0}; wb_val = {32'h0, 32'h44}; step();
        idle(); #1;
        check("store_slots", {cm0_valid, cm1_valid}, 2'b10);
        check("store_id", cm0_id, 0);
        step();
        check("reg_after_store", {cm0_valid, cm0_id, cm0_val}, {1'b1, 4'd1, 32'h33});
        step();

        // Mispredicted branch, alloc during the flush cycle dropped.
        do_reset();
        alloc_set(0, 0, 5'd0, 2'd2, 32'h100); step();
        idle(); alloc_set(0, 0, 5'd6, 2'd0, 0); step();
        idle(); alloc_set(0, 0, 5'd7, 2'd0, 0); step();
        idle(); wb_valid = 2'b01; wb_id = 0; wb_val = {32'h0, 32'h200}; step();
        idle(); #1;
        check("br_commit", {cm0_valid, cm1_valid}, 2'b10);
        step();
        alloc_set(1, 32'h99, 5'd8, 2'd0, 0); #1;
        check("flush_hi", {flush, flush_pc}, {1'b1, 32'h200});
        step();
        idle(); #1;
        check("post_flush", {flush, rob_count, head_id, alloc_id}, 0);
        step();

        // Query forwarding from writeback and from the allocation port.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            idle(); alloc_set(0, 0, 5'(i + 1), 2'd0, 0); step();
        end
        idle();
        alloc_set(1, 32'h5555, 5'd7, 2'd0, 0);
        q_id = {4'd4, 4'd3};
        wb_valid = 2'b10; wb_id = {4'd3, 4'd0}; wb_val = {32'hABCD, 32'h0};
        #1;
        check("q_fwd_ready", q_ready, 2'b11);
        check("q_fwd_val", q_val, {32'h5555, 32'hABCD});
        step();

        // Wrap with periodic stalls.
        do_reset();
        for (int i = 0; i < 13; i++) begin
            idle(); alloc_set(0, 0, 5'd1, 2'd0, 0); step();
        end
        idle(); step();
        for (int i = 0; i < 13; i++) begin
            idle(); wb_valid = 2'b01; wb_id = 8'(i); wb_val = 64'(32'h1000 + i); step();
        end
        done_allocs = 0; c = 0;
        while (done_allocs < 20) begin
            idle();
            rdy_in = (c % 3 != 2);
            alloc_set(1, $urandom, 5'($urandom), 2'd0, 0);
            cnt_before = rob_count;
            step();
            if (!rdy_in) check("freeze_count", rob_count, cnt_before);
            else done_allocs++;
            c++;
        end
        rdy_in = 1; idle();
        repeat (4) step();

        // Randomised traffic.
        do_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            idle();
            rdy_in = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 9) < 6) begin
                logic [1:0]  t;
                logic [31:0] v;
                t = 2'($urandom);
                v = $urandom;
                alloc_set($urandom_range(0, 1), v, 5'($urandom), t,
                          ($urandom_range(0, 5) == 0) ? v ^ 32'h4 : v);
            end
            for (int k = 0; k < NWB; k++) begin
                if ($urandom_range(0, 1) == 1) begin
                    wb_valid[k] = 1;
                    if (mq.size() > 0) begin
                        idx = $urandom_range(0, mq.size() - 1);
                        wb_id[k*W +: W] = mq[idx].id;
                        wb_val[k*32 +: 32] = (mq[idx].typ == 2'd2 && $urandom_range(0, 5) != 0)
                                             ? mq[idx].pred : $urandom;
                    end else begin
                        wb_id[k*W +: W] = W'($urandom);
                        wb_val[k*32 +: 32] = $urandom;
                    end
                end
            end
            if ($urandom_range(0, 19) == 0) begin
                wb_valid = 2'b11; wb_id[2*W-1:W] = wb_id[W-1:0];
            end
            q_id = 8'($urandom);
            step();
        end

        do_reset();
        check("final_rst", {flush, flush_pc, rob_count, head_id, alloc_id}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rob_multi_commit.md
Name: rob_multi_commit

Overview:
- Parametrised reorder buffer, successor to the single-commit ROB in the Execute stage.
- Allocates one entry per cycle from the Decoder and accepts NUM_WB writeback ports (RS, LSB, extra units).
- Retires up to two entries per cycle in program order to RegFile/LSB.
- Detects branch mispredicts by full target comparison and raises a registered flush with the corrected PC.

Parameters:
- ROB_WIDTH_BIT, 4, log2 of depth; DEPTH = 1<<ROB_WIDTH_BIT.
- NUM_WB, 2, number of writeback ports.
- DUAL_COMMIT, 1, 1 enables the second commit slot; 0 gives single commit.

Ports:
- clk_in  in  1  clock
- rst_in  in  1  synchronous active-high reset
- rdy_in  in  1  pause when low
- alloc_valid  in  1  Decoder pushes instruction
- alloc_done  in  1  result already known at allocation
- alloc_value  in  32  result if done / actual target
- alloc_rd  in  5  destination register
- alloc_type  in  2  0 REG, 1 STORE, 2 BRANCH, 3 LOAD
- alloc_pc  in  32  instruction address
- alloc_pred  in  32  predicted next PC (BRANCH)
- alloc_id  out  ROB_WIDTH_BIT  current tail
- rob_full  out  1  count == DEPTH
- rob_count  out  ROB_WIDTH_BIT+1  occupancy
- wb_valid  in  NUM_WB  writeback strobes
- wb_id  in  NUM_WB*ROB_WIDTH_BIT  flattened, port k at [k*W +: W]
- wb_val  in  NUM_WB*32  flattened values
- cm0_valid, cm1_valid  out  1 each  slot retires this cycle
- cm0_wr, cm1_wr  out  1 each  retire writes a register (REG/LOAD, rd != 0)
- cm0_rd, cm1_rd  out  5 each
- cm0_val, cm1_val  out  32 each
- cm0_id, cm1_id  out  ROB_WIDTH_BIT each
- head_is_mem  out  1  head busy and STORE/LOAD
- head_id  out  ROB_WIDTH_BIT
- q_id  in  2*ROB_WIDTH_BIT  two dependency queries
- q_ready  out  2  per query
- q_val  out  64  per query
- flush  out  1  registered mispredict flush
- flush_pc  out  32  corrected PC

Behaviour:
- Reset (rst_in high at clock edge):
  - head, tail, count = 0; all busy/done = 0.
  - flush = 0, flush_pc = 0.
  - All cm*_valid/wr = 0.
  - Reset overrides everything, including a flush in progress.
- rdy_in low:
  - All state frozen.
  - cm*_valid, cm*_wr forced 0.
  - Queries still answered combinationally.
- Allocation, when alloc_valid && !rob_full && !flush:
  - Entry[tail] <= busy = 1, done = alloc_done, plus all fields.
  - tail <= tail+1, wrapping mod DEPTH.
  - alloc_valid while full is ignored. The Decoder must gate on rob_full.
- Writeback, port k with wb_valid[k] and entry busy:
  - Entry done = 1, value = wb_val.
  - Writeback to a non-busy entry is ignored.
  - Same id on several ports: highest k wins.
  - Writeback and commit of the same entry in one cycle: the commit uses the old state, so it does not occur because done was 0.
- Commit slot 0 (combinational): cm0_valid = rdy_in && !flush && busy[head] && done[head].
- Commit slot 1: cm1_valid requires all of:
  - DUAL_COMMIT = 1
  - cm0_valid
  - type[head] != BRANCH
  - neither entry is STORE or LOAD
  - busy[head+1] && done[head+1]
- head advances by cm0_valid + cm1_valid; retired entries are cleared.
- rob_count <= count + alloc_accepted - commits. Full and empty are distinguished by count, never by head == tail.
- Mispredict:
  - Slot 0 retires a BRANCH whose value != pred (full 32-bit compare).
  - Next cycle: flush = 1, flush_pc = value.
  - A correct branch commits silently.
- Flush cycle (flush high, rdy_in high):
  - head = tail = count = 0, all busy/done cleared, flush <= 0.
  - Allocations and writebacks in this cycle are dropped.
  - If rdy_in is low, flush is held high.
- Query q (combinational), priority order:
  1. Stored done[id] gives the stored value.
  2. Otherwise a matching wb port this cycle, highest k first.
  3. Otherwise alloc_valid && alloc_done && id == tail gives alloc_value.
  4. Otherwise q_ready = 0 and q_val = 0.
- head_is_mem and head_id reflect registered head state.

Test Plan:
- Reset, then 16 REG allocs with alloc_done = 0 (DEPTH 16) → rob_full = 1, rob_count = 16. A 17th alloc is ignored and tail stays 0.
- Fill ids 0,1, then wb port0 id1 val 0x22 and port1 id0 val 0x11 in the same cycle → next cycle cm0 id0 val 0x11 and cm1 id1 val 0x22 both valid, head = 2.
- Entry 0 is a STORE (done), entry 1 is a REG (done) → cycle 1 commits only cm0. The next cycle commits id1 on slot 0.
- BRANCH pred 0x100, wb value 0x200, younger entries busy → after commit, flush = 1 and flush_pc = 0x200 for one cycle. Then count = 0, head = tail = 0, and an alloc during the flush cycle is dropped.
- Query id 3 (not done) while wb port1 writes id3 = 0xABCD → q_ready = 1, q_val = 0xABCD in the same cycle. A query of the tail with alloc_done = 1 returns alloc_value.
- Wrap: perform 20 alloc/commit pairs with rdy_in toggled low every third cycle → no state change while rdy_in is low. Commits stay in order across the 15 to 0 wrap, and count never exceeds 16.
